// File: rtl/btn_arb_pkg.sv
// ---------------------------------------------------------------------------
// btn_arb_pkg
// Shared constants and helpers for the button event arbiter.
//   N_REQ_DEFAULT : default number of button requesters
//   ID_W          : requester index width for the default configuration
//   DROP_CNT_W    : width of the optional coalesced-pulse counter
//   popcnt16()    : number of set bits in a 16-bit vector
// ---------------------------------------------------------------------------
package btn_arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int ID_W          = $clog2(N_REQ_DEFAULT);
  localparam int DROP_CNT_W    = 8;

  // Wide enough for 2 * 8 requesters (short + long drops in one cycle).
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req[] starting at ptr+1 and
// wrapping modulo N_REQ; the first set bit found is granted.
// Ports:
//   req       : per-requester eligibility
//   ptr       : index of the last granted requester
//   gnt_valid : at least one requester is eligible
//   gnt_id    : index of the granted requester (0 when gnt_valid=0)
// ---------------------------------------------------------------------------
module rr_pick
  import btn_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int ID_BITS = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [ID_BITS-1:0] ptr,
  output logic               gnt_valid,
  output logic [ID_BITS-1:0] gnt_id
);

  logic [ID_BITS-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit after ptr
  // overwrites any farther one; offset N_REQ wraps back to ptr itself.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    w_idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = ID_BITS'((int'(ptr) + k) % N_REQ);
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// ---------------------------------------------------------------------------
// btn_event_arbiter
// Captures per-requester short/long button event pulses into pending bits
// and issues them one at a time as commands through a valid/ready output
// register, selecting requesters round-robin (long before short within a
// requester).
// Optional feature macro: BTN_ARB_DROP_CNT_EN adds the drop_cnt output, a
// saturating count of pulses coalesced into an already-pending bit.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   ev_short, ev_long   : one-cycle event pulses per requester
//   arb_en              : grant enable (events still captured when low)
//   flush               : synchronous clear of all pending events
//   cmd_valid/id/long   : presented command
//   cmd_ready           : consumer accepts the command
//   drop_cnt            : coalesced-pulse counter (macro only)
// ---------------------------------------------------------------------------
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          ev_short,
  input  logic [N_REQ-1:0]          ev_long,
  input  logic                      arb_en,
  input  logic                      flush,
  output logic                      cmd_valid,
  output logic [$clog2(N_REQ)-1:0]  cmd_id,
  output logic                      cmd_long,
  input  logic                      cmd_ready
`ifdef BTN_ARB_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);

  localparam int CMD_ID_W = $clog2(N_REQ);

  // State
  logic [N_REQ-1:0]    r_pend_s;
  logic [N_REQ-1:0]    r_pend_l;
  logic [CMD_ID_W-1:0] r_rr_ptr;
  logic                r_cmd_valid;
  logic [CMD_ID_W-1:0] r_cmd_id;
  logic                r_cmd_long;

  // Next-state / combinational
  logic [N_REQ-1:0]    w_req;
  logic                w_free;
  logic                w_gnt_valid;
  logic [CMD_ID_W-1:0] w_gnt_id;
  logic                w_load;
  logic                w_load_long;
  logic [N_REQ-1:0]    w_hit;
  logic [N_REQ-1:0]    w_clr_s;
  logic [N_REQ-1:0]    w_clr_l;
  logic [N_REQ-1:0]    w_pend_s_next;
  logic [N_REQ-1:0]    w_pend_l_next;
  logic [CMD_ID_W-1:0] w_rr_ptr_next;
  logic                w_cmd_valid_next;
  logic [CMD_ID_W-1:0] w_cmd_id_next;
  logic                w_cmd_long_next;

  assign w_req  = r_pend_s | r_pend_l;
  assign w_free = ~r_cmd_valid | cmd_ready;

  rr_pick #(
    .N_REQ   (N_REQ),
    .ID_BITS (CMD_ID_W)
  ) u_rr_pick (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_load      = w_free & arb_en & ~flush & w_gnt_valid;
  // Long wins within the granted requester; short stays pending.
  assign w_load_long = r_pend_l[w_gnt_id];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hit
    assign w_hit[gi] = w_load & (w_gnt_id == CMD_ID_W'(gi));
  end

  assign w_clr_l = w_hit & {N_REQ{w_load_long}};
  assign w_clr_s = w_hit & {N_REQ{~w_load_long}};

  // A pulse in the load cycle re-sets the bit being cleared; flush beats all.
  assign w_pend_s_next = flush ? '0 : ((r_pend_s & ~w_clr_s) | ev_short);
  assign w_pend_l_next = flush ? '0 : ((r_pend_l & ~w_clr_l) | ev_long);

  always_comb begin
    w_cmd_valid_next = r_cmd_valid;
    w_cmd_id_next    = r_cmd_id;
    w_cmd_long_next  = r_cmd_long;
    w_rr_ptr_next    = r_rr_ptr;
    if (w_load) begin
      w_cmd_valid_next = 1'b1;
      w_cmd_id_next    = w_gnt_id;
      w_cmd_long_next  = w_load_long;
      w_rr_ptr_next    = w_gnt_id;
    end else if (w_free) begin
      w_cmd_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_s    <= '0;
      r_pend_l    <= '0;
      r_rr_ptr    <= CMD_ID_W'(N_REQ - 1);
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_cmd_long  <= 1'b0;
    end else begin
      r_pend_s    <= w_pend_s_next;
      r_pend_l    <= w_pend_l_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_id    <= w_cmd_id_next;
      r_cmd_long  <= w_cmd_long_next;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_id    = r_cmd_id;
  assign cmd_long  = r_cmd_long;

`ifdef BTN_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [N_REQ-1:0]      w_drop_s;
  logic [N_REQ-1:0]      w_drop_l;
  logic [4:0]            w_drop_num;
  logic [DROP_CNT_W:0]   w_drop_sum;
  logic [DROP_CNT_W-1:0] w_drop_cnt_next;

  // A pulse is coalesced only if its bit stays set through this edge
  // without it; flush discards pulses without counting them.
  assign w_drop_s   = ev_short & r_pend_s & ~w_clr_s & {N_REQ{~flush}};
  assign w_drop_l   = ev_long  & r_pend_l & ~w_clr_l & {N_REQ{~flush}};
  assign w_drop_num = popcnt16(16'({w_drop_l, w_drop_s}));
  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'(w_drop_num);
  assign w_drop_cnt_next = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_btn_event_arbiter
// Directed scenarios plus randomized traffic for btn_event_arbiter, checked
// every cycle against a behavioural model of pending events, round-robin
// choice and the output handshake.
// ---------------------------------------------------------------------------
module tb_btn_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] ev_short;
  logic [N-1:0] ev_long;
  logic         arb_en;
  logic         flush;
  logic         cmd_ready;
  logic         cmd_valid;
  logic [1:0]   cmd_id;
  logic         cmd_long;
`ifdef BTN_ARB_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  btn_event_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ev_short  (ev_short),
    .ev_long   (ev_long),
    .arb_en    (arb_en),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_long  (cmd_long),
    .cmd_ready (cmd_ready)
`ifdef BTN_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid;
  bit m_long;
  int m_id;
  int m_ptr;
  int m_drop;
  bit m_ps[N];
  bit m_pl[N];

  task automatic model_reset();
    m_valid = 0;
    m_long  = 0;
    m_id    = 0;
    m_ptr   = N - 1;
    m_drop  = 0;
    for (int i = 0; i < N; i++) begin
      m_ps[i] = 0;
      m_pl[i] = 0;
    end
  endtask

  // One clock edge: decide who is served from the events waiting before the
  // edge, then fold in this cycle's pulses.
  task automatic model_tick();
    bit free;
    bit load;
    bit take_long;
    int g;
    bit keep_s;
    bit keep_l;
    free = !m_valid || cmd_ready;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && (m_ps[i] || m_pl[i])) g = i;
    end
    load      = free && arb_en && !flush && (g >= 0);
    take_long = load ? m_pl[g] : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (flush) begin
        m_ps[i] = 0;
        m_pl[i] = 0;
      end else begin
        keep_l = m_pl[i] && !(load && i == g && take_long);
        keep_s = m_ps[i] && !(load && i == g && !take_long);
        if (ev_long[i]) begin
          if (keep_l) m_drop++;
          keep_l = 1;
        end
        if (ev_short[i]) begin
          if (keep_s) m_drop++;
          keep_s = 1;
        end
        m_pl[i] = keep_l;
        m_ps[i] = keep_s;
      end
    end
    if (m_drop > 255) m_drop = 255;
    if (load) begin
      m_valid = 1;
      m_id    = g;
      m_long  = take_long;
      m_ptr   = g;
    end else if (free) begin
      m_valid = 0;
    end
  endtask

  task automatic compare();
    check_eq("cmd_valid", cmd_valid, m_valid);
    if (m_valid) begin
      check_eq("cmd_id", cmd_id, m_id);
      check_eq("cmd_long", cmd_long, m_long);
    end
`ifdef BTN_ARB_DROP_CNT_EN
    check_eq("drop_cnt", drop_cnt, m_drop);
`endif
    $display("cyc %0d en=%0b fl=%0b rdy=%0b es=%b el=%b -> v=%0b id=%0d long=%0b",
             cyc, arb_en, flush, cmd_ready, ev_short, ev_long, cmd_valid, cmd_id, cmd_long);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    cyc++;
    #1;
    compare();
  endtask

  // Clock edge, then asynchronous reset in mid-cycle, released after the next edge.
  task automatic do_reset();
    step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_valid", cmd_valid, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    compare();
  endtask

  task automatic clear_ev();
    ev_short = '0;
    ev_long  = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    clear_ev();
    arb_en    = 1'b1;
    flush     = 1'b0;
    cmd_ready = 1'b1;
    model_reset();
    #1;
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_id", cmd_id, 0);
    check_eq("rst_long", cmd_long, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    compare();

    // Single short press on requester 2: visible only two edges later.
    ev_short = 4'b0100;
    step();
    check_eq("s34_lat1", cmd_valid, 0);
    clear_ev();
    step();
    check_eq("s34_valid", cmd_valid, 1);
    check_eq("s34_id", cmd_id, 2);
    check_eq("s34_long", cmd_long, 0);
    step();
    check_eq("s34_once", cmd_valid, 0);

    // All four requesters at once: back-to-back 0,1,2,3.
    do_reset();
    ev_short = 4'b1111;
    step();
    clear_ev();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("s35_valid", cmd_valid, 1);
      check_eq("s35_id", cmd_id, k);
    end
    step();
    check_eq("s35_done", cmd_valid, 0);

    // Long and short together on requester 1: long first.
    ev_long  = 4'b0010;
    ev_short = 4'b0010;
    step();
    clear_ev();
    step();
    check_eq("s36_id0", cmd_id, 1);
    check_eq("s36_long0", cmd_long, 1);
    step();
    check_eq("s36_id1", cmd_id, 1);
    check_eq("s36_long1", cmd_long, 0);

    // Stalled consumer with repeated pulses on requester 3.
    do_reset();
    cmd_ready = 1'b0;
    ev_short  = 4'b1000;
    step();
    clear_ev();
    step();
    for (int c = 0; c < 5; c++) begin
      ev_short = (c < 3) ? 4'b1000 : 4'b0000;
      step();
      check_eq("s37_hold_v", cmd_valid, 1);
      check_eq("s37_hold_id", cmd_id, 3);
      check_eq("s37_hold_l", cmd_long, 0);
    end
    clear_ev();
    cmd_ready = 1'b1;
    step();
    check_eq("s37_again_v", cmd_valid, 1);
    check_eq("s37_again_id", cmd_id, 3);
    step();
    check_eq("s37_end", cmd_valid, 0);
`ifdef BTN_ARB_DROP_CNT_EN
    check_eq("s37_drop", drop_cnt, 2);
`endif

    // Pending on 0 and 2 while disabled, then flushed: nothing ever issues.
    do_reset();
    arb_en   = 1'b0;
    ev_short = 4'b0101;
    step();
    clear_ev();
    repeat (3) begin
      step();
      check_eq("s38_dis", cmd_valid, 0);
    end
    flush = 1'b1;
    step();
    flush  = 1'b0;
    arb_en = 1'b1;
    repeat (3) begin
      step();
      check_eq("s38_flushed", cmd_valid, 0);
    end

    // Reset while a command is presented, then requester 0 wins first.
    cmd_ready = 1'b0;
    ev_long   = 4'b0100;
    step();
    clear_ev();
    step();
    check_eq("s39_pre_v", cmd_valid, 1);
    do_reset();
    cmd_ready = 1'b1;
    ev_short  = 4'b1001;
    step();
    clear_ev();
    step();
    check_eq("s39_first", cmd_id, 0);
    step();
    check_eq("s39_second", cmd_id, 3);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        ev_short[i] = ($urandom % 6) == 0;
        ev_long[i]  = ($urandom % 10) == 0;
      end
      cmd_ready = ($urandom % 4) != 0;
      arb_en    = ($urandom % 8) != 0;
      flush     = ($urandom % 40) == 0;
      if (($urandom % 500) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end
    clear_ev();
    flush     = 1'b0;
    arb_en    = 1'b1;
    cmd_ready = 1'b1;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of button requesters (2..8).
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock; the single clock domain.
REQ-003 The block SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port ev_short, input, N_REQ, meaning the per-requester one-cycle short-press pulses from the debounce blocks.
REQ-005 The block SHALL have port ev_long, input, N_REQ, meaning the per-requester one-cycle long/held-repeat pulses.
REQ-006 The block SHALL have port arb_en, input, 1, meaning a grant enable; events are still captured while it is low.
REQ-007 The block SHALL have port flush, input, 1, meaning a synchronous clear of all pending events.
REQ-008 The block SHALL have port cmd_valid, output, 1, meaning a command is presented.
REQ-009 The block SHALL have port cmd_id, output, $clog2(N_REQ), meaning the requester index of the command.
REQ-010 The block SHALL have port cmd_long, output, 1, meaning 1 for a long event and 0 for a short event.
REQ-011 The block SHALL have port cmd_ready, input, 1, meaning the consumer accepts the command.

Function
REQ-012 The block SHALL hold pending bits pend_s[i] and pend_l[i]; a pulse on ev_short[i] or ev_long[i] SHALL set the matching bit at the next clk edge.
REQ-013 A pulse arriving while its pending bit is already 1 SHALL be coalesced (no second command) and counted as a drop.
REQ-014 The output register SHALL be "free" when cmd_valid=0, or when cmd_valid=1 and cmd_ready=1.
REQ-015 When the output register is free, arb_en=1, flush=0 and any pending bit is set, the block SHALL load one command in that cycle.
REQ-016 Requester selection SHALL be round-robin, searching from rr_ptr+1 modulo N_REQ; rr_ptr SHALL take the granted id on each load.
REQ-017 Within the selected requester, the long event SHALL be issued before the short event; the short pending bit stays set for a later grant.
REQ-018 The loaded pending bit SHALL be cleared on load; a new pulse for that same bit in the load cycle SHALL win, so the bit stays 1.
REQ-019 While cmd_valid=1 and cmd_ready=0, cmd_id and cmd_long SHALL remain stable.
REQ-020 Latency SHALL be 2 cycles from an event pulse to cmd_valid with an idle arbiter: edge 1 sets the pending bit, edge 2 loads the output.
REQ-021 Back-to-back throughput SHALL be one command per cycle while cmd_ready=1.
REQ-022 If the output is free and nothing is eligible (or arb_en=0), cmd_valid SHALL deassert at the next edge.
REQ-023 flush=1 SHALL clear all pending bits, including pulses arriving in the same cycle, and SHALL inhibit loading; an already-presented command SHALL stay until accepted.
REQ-024 With arb_en=0, an already-presented command SHALL complete normally and no new command SHALL load.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately clear cmd_valid, cmd_id, cmd_long, all pend_s and pend_l bits, and drop_cnt (when present).
REQ-026 Asserting reset_n=0 SHALL immediately set rr_ptr=N_REQ-1, so that requester 0 wins first.
REQ-027 Reset asserted mid-handshake SHALL discard the presented command without an acceptance.

Configuration
REQ-028 With BTN_ARB_DROP_CNT_EN defined, the block SHALL add output port drop_cnt [7:0], incremented by the number of coalesced pulses each cycle and saturating at 255.
REQ-029 Under BTN_ARB_DROP_CNT_EN, coalesced pulses dropped because of flush SHALL NOT be counted.
REQ-030 Without BTN_ARB_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package btn_arb_pkg SHALL hold N_REQ_DEFAULT=4, ID_W, and DROP_CNT_W=8.
REQ-032 Sub-module rr_pick SHALL hold the combinational round-robin picker: inputs req[N_REQ] and ptr; outputs gnt_valid and gnt_id.
REQ-033 All state SHALL live in btn_event_arbiter.

Verification
REQ-034 Scenario: ev_short[2] pulses at cycle 0 with cmd_ready=1 -> cmd_valid=1 with cmd_id=2 and cmd_long=0 in cycle 2 only.
REQ-035 Scenario: ev_short on 0,1,2,3 all at cycle 0 with cmd_ready=1 -> ids 0,1,2,3 on consecutive cycles 2..5.
REQ-036 Scenario: ev_long[1] and ev_short[1] pulse together -> cmd (1,long) then cmd (1,short) on the next grant.
REQ-037 Scenario: cmd_ready=0 for 5 cycles with cmd (3,short) presented, and ev_short[3] pulses 3 more times -> cmd held stable, then one further (3,short) after acceptance, and drop_cnt=2.
REQ-038 Scenario: pending on 0 and 2, arb_en=0 for 4 cycles then flush for 1 cycle -> no command is issued and all pending bits are 0.
REQ-039 Scenario: reset_n pulled low while cmd_valid=1 -> cmd_valid=0 immediately; after release, ev_short[3] and ev_short[0] together -> id 0 is granted first.
